// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register file.
//   axil_resp_t  : 2-bit AXI response code
//   AXIL_OKAY    : normal completion
//   AXIL_SLVERR  : access outside the register window
//   wr_state_t   : write channel FSM states
//   rd_state_t   : read channel FSM states
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t AXIL_OKAY   = 2'b00;
  localparam axil_resp_t AXIL_SLVERR = 2'b10;

  // W_ADDR: address captured, waiting for data.
  // W_DATA: data/strobe captured, waiting for address.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational address decoder for the register window.
//   addr : byte address from AW or AR channel
//   hit  : address falls inside [BASE_ADDR, BASE_ADDR + NUM_REGS*4)
//   idx  : register index (word offset); only meaningful when hit=1
// The offset is computed with 32-bit wrap, so addresses below BASE_ADDR
// become large offsets and miss. addr[1:0] is ignored.
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 16,
  parameter int          IDX_W     = 4
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [31:0] off;
  logic        unused_off;

  assign off        = addr - BASE_ADDR;
  assign hit        = (off < 32'(NUM_REGS * 4));
  assign idx        = off[IDX_W+1:2];
  // Byte-lane bits and bits above the index are intentionally dropped.
  assign unused_off = &{1'b0, off};

endmodule

// File: rtl/s_axil_regfile.sv
// AXI4-Lite slave register file.
//   clk, rst_n          : clock, synchronous active-low reset
//   s_axil_aw*/w*/b*    : write address, write data, write response channels
//   s_axil_ar*/r*       : read address, read data channels
//   reg_q               : flat register contents, reg i at [32i+31:32i]
//   wr_pulse            : one-cycle pulse per register on an OKAY write
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the source holds payload stable while valid is high and ready
// is low. Every output is driven from a flop, so no input reaches an output
// combinationally. Read and write channels run as independent FSMs.
module s_axil_regfile
  import axil_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [31:0]              s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic unused_prot;
  assign unused_prot = &{1'b0, s_axil_awprot, s_axil_arprot};

  // ---------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------
  logic [31:0] regs [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[32*g +: 32] = regs[g];
  end

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic             aw_hit, ar_hit;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  axil_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_aw_decode (
    .addr (s_axil_awaddr),
    .hit  (aw_hit),
    .idx  (aw_idx)
  );

  axil_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_ar_decode (
    .addr (s_axil_araddr),
    .hit  (ar_hit),
    .idx  (ar_idx)
  );

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  wr_state_t        wr_state, wr_state_d;
  logic             aw_hs, w_hs;
  logic             commit, cap_aw, cap_w;
  logic             aw_hit_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             cm_hit;
  logic [IDX_W-1:0] cm_idx;
  logic [31:0]      cm_data;
  logic [3:0]       cm_strb;
  logic             awready_d, wready_d, bvalid_d;
  logic [NUM_REGS-1:0] pulse_d;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid  & s_axil_wready;

  always_comb begin
    wr_state_d = wr_state;
    commit     = 1'b0;
    cap_aw     = 1'b0;
    cap_w      = 1'b0;
    // The commit operands come from the live channel unless that half was
    // captured earlier in W_ADDR / W_DATA.
    cm_hit     = aw_hit;
    cm_idx     = aw_idx;
    cm_data    = s_axil_wdata;
    cm_strb    = s_axil_wstrb;
    unique case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end else if (aw_hs) begin
          cap_aw     = 1'b1;
          wr_state_d = W_ADDR;
        end else if (w_hs) begin
          cap_w      = 1'b1;
          wr_state_d = W_DATA;
        end
      end
      W_ADDR: begin
        cm_hit = aw_hit_q;
        cm_idx = aw_idx_q;
        if (w_hs) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_DATA: begin
        cm_data = wdata_q;
        cm_strb = wstrb_q;
        if (aw_hs) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axil_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase

    // Readies are registered from the next state, which also keeps them low
    // through reset and lets them rise on the first edge after release.
    awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_DATA);
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_ADDR);
    bvalid_d  = (wr_state_d == W_RESP);

    for (int i = 0; i < NUM_REGS; i++) begin
      pulse_d[i] = commit && cm_hit && (cm_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state       <= W_IDLE;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= AXIL_OKAY;
      wr_pulse       <= '0;
      aw_hit_q       <= 1'b0;
      aw_idx_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
    end else begin
      wr_state       <= wr_state_d;
      s_axil_awready <= awready_d;
      s_axil_wready  <= wready_d;
      s_axil_bvalid  <= bvalid_d;
      wr_pulse       <= pulse_d;
      if (commit) s_axil_bresp <= cm_hit ? AXIL_OKAY : AXIL_SLVERR;
      if (cap_aw) begin
        aw_hit_q <= aw_hit;
        aw_idx_q <= aw_idx;
      end
      if (cap_w) begin
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst_n) begin
        regs[i] <= RESET_VAL;
      end else if (pulse_d[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (cm_strb[b]) regs[i][8*b +: 8] <= cm_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  rd_state_t rd_state, rd_state_d;
  logic      ar_hs;

  assign ar_hs = s_axil_arvalid & s_axil_arready;

  always_comb begin
    rd_state_d = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_d = R_RESP;
      R_RESP:  if (s_axil_rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // rdata samples regs before any same-edge write lands, so a colliding
  // read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state       <= R_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= AXIL_OKAY;
    end else begin
      rd_state       <= rd_state_d;
      s_axil_arready <= (rd_state_d == R_IDLE);
      s_axil_rvalid  <= (rd_state_d == R_RESP);
      if (ar_hs) begin
        s_axil_rdata <= ar_hit ? regs[ar_idx] : 32'h0;
        s_axil_rresp <= ar_hit ? AXIL_OKAY : AXIL_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_s_axil_regfile.sv
// Directed testbench for s_axil_regfile (NUM_REGS=16, BASE_ADDR=0, RESET_VAL=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_s_axil_regfile;

  localparam int NR = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       awaddr, wdata, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]        wstrb;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata;
  logic [32*NR-1:0]  reg_q;
  logic [NR-1:0]     wr_pulse;

  logic [31:0]       exp_regs [NR];
  int                checks = 0;
  int                errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  s_axil_regfile #(
    .NUM_REGS  (NR),
    .BASE_ADDR (32'h0000_0000),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .reg_q          (reg_q),
    .wr_pulse       (wr_pulse)
  );

  function automatic logic [32*NR-1:0] exp_flat();
    logic [32*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = exp_regs[i];
    return v;
  endfunction

  function automatic logic [31:0] reg_word(input int i);
    return reg_q[32*i +: 32];
  endfunction

  // driver tasks
  task automatic drive_idle();
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
  endtask

  task automatic drive_aw(input logic [31:0] a);
    awaddr = a; awvalid = 1'b1;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1'b1;
  endtask

  task automatic drive_ar(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b expected 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata, wr_pulse} !== '0) begin
      errors++; $display("FAIL reset_resp got %h/%h/%h/%h expected 0", bresp, rresp, rdata, wr_pulse);
    end
    checks++;
    if (reg_q !== exp_flat()) begin
      errors++; $display("FAIL reset_regs got %h expected %h", reg_q, exp_flat());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL reset_release_readies got %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    drive_aw(32'h08); drive_w(32'hDEAD_BEEF, 4'hF); bready = 1'b1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    exp_regs[2] = 32'hDEAD_BEEF;
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      errors++; $display("FAIL wr_same_b got bvalid=%b bresp=%b expected 1/00", bvalid, bresp);
    end
    checks++;
    if (wr_pulse !== 16'h0004) begin
      errors++; $display("FAIL wr_same_pulse got %h expected 0004", wr_pulse);
    end
    checks++;
    if (reg_q !== exp_flat()) begin
      errors++; $display("FAIL wr_same_regs got %h expected %h", reg_word(2), exp_regs[2]);
    end
    @(negedge clk);
    checks++;
    if ({bvalid, wr_pulse, awready, wready} !== {1'b0, 16'h0, 2'b11}) begin
      errors++; $display("FAIL wr_same_after got bvalid=%b pulse=%h rdy=%b%b expected 0/0000/11", bvalid, wr_pulse, awready, wready);
    end
    bready = 1'b0;
  endtask

  task automatic test_w_before_aw();
    drive_w(32'h1122_3344, 4'b0101);
    @(negedge clk);
    wvalid = 0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b100) begin
      errors++; $display("FAIL wfirst_ready got aw=%b w=%b b=%b expected 1/0/0", awready, wready, bvalid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({wready, bvalid, wr_pulse} !== '0) begin
      errors++; $display("FAIL wfirst_wait got w=%b b=%b pulse=%h expected 0/0/0000", wready, bvalid, wr_pulse);
    end
    drive_aw(32'h08);
    @(negedge clk);
    awvalid = 0;
    exp_regs[2] = 32'hDE22_BE44;
    checks++;
    if ({bvalid, bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0004}) begin
      errors++; $display("FAIL wfirst_b got b=%b resp=%b pulse=%h expected 1/00/0004", bvalid, bresp, wr_pulse);
    end
    checks++;
    if (reg_q !== exp_flat()) begin
      errors++; $display("FAIL wfirst_regs got %h expected %h", reg_word(2), exp_regs[2]);
    end
    @(negedge clk);
    checks++;
    if ({bvalid, bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0}) begin
      errors++; $display("FAIL wfirst_hold got b=%b resp=%b pulse=%h expected 1/00/0000", bvalid, bresp, wr_pulse);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++; $display("FAIL wfirst_single_b got b=%b rdy=%b%b expected 0/11", bvalid, awready, wready);
    end
  endtask

  task automatic test_read_backpressure();
    drive_ar(32'h08); rready = 1'b0;
    @(negedge clk);
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'hDE22_BE44}) begin
        errors++; $display("FAIL rd_hold[%0d] got rv=%b ar=%b resp=%b data=%h expected 1/0/00/de22be44", i, rvalid, arready, rresp, rdata);
      end
      if (i < 4) @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL rd_done got rv=%b ar=%b expected 0/1", rvalid, arready);
    end
  endtask

  task automatic test_decode_miss();
    drive_aw(32'h40); drive_w(32'hFFFF_FFFF, 4'hF); bready = 1'b1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    checks++;
    if ({bvalid, bresp, wr_pulse} !== {1'b1, 2'b10, 16'h0}) begin
      errors++; $display("FAIL miss_b got b=%b resp=%b pulse=%h expected 1/10/0000", bvalid, bresp, wr_pulse);
    end
    checks++;
    if (reg_q !== exp_flat()) begin
      errors++; $display("FAIL miss_regs got %h expected %h", reg_q, exp_flat());
    end
    @(negedge clk);
    bready = 1'b0;
    drive_ar(32'h44);
    @(negedge clk);
    arvalid = 0;
    checks++;
    if ({rvalid, rresp, rdata, wr_pulse} !== {1'b1, 2'b10, 32'h0, 16'h0}) begin
      errors++; $display("FAIL miss_r got rv=%b resp=%b data=%h pulse=%h expected 1/10/0/0", rvalid, rresp, rdata, wr_pulse);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_read_write_collision();
    drive_aw(32'h0C); drive_w(32'hAAAA_5555, 4'hF); drive_ar(32'h0C);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_regs[3] = 32'hAAAA_5555;
    checks++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h0}) begin
      errors++; $display("FAIL coll_old_value got rv=%b resp=%b data=%h expected 1/00/00000000", rvalid, rresp, rdata);
    end
    checks++;
    if ({bvalid, wr_pulse} !== {1'b1, 16'h0008} || reg_q !== exp_flat()) begin
      errors++; $display("FAIL coll_write got b=%b pulse=%h reg3=%h expected 1/0008/aaaa5555", bvalid, wr_pulse, reg_word(3));
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    drive_ar(32'h0C);
    @(negedge clk);
    arvalid = 0;
    checks++;
    if ({rvalid, rdata} !== {1'b1, 32'hAAAA_5555}) begin
      errors++; $display("FAIL coll_reread got rv=%b data=%h expected 1/aaaa5555", rvalid, rdata);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset_pending();
    drive_aw(32'h00); drive_w(32'h0000_0005, 4'hF);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    exp_regs[0] = 32'h5;
    checks++;
    if (bvalid !== 1'b1 || reg_q !== exp_flat()) begin
      errors++; $display("FAIL rstp_setup got b=%b reg0=%h expected 1/00000005", bvalid, reg_word(0));
    end
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    checks++;
    if ({bvalid, awready, wready, arready, wr_pulse} !== '0 || reg_q !== exp_flat()) begin
      errors++; $display("FAIL rstp_during got b=%b rdy=%b%b%b reg0=%h expected 0/000/0", bvalid, awready, wready, arready, reg_word(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0111) begin
      errors++; $display("FAIL rstp_after got b=%b rdy=%b%b%b expected 0/111", bvalid, awready, wready, arready);
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_backpressure();
    test_decode_miss();
    test_read_write_collision();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
